apb_reg_demux: RTL and testbench
================================

Name: apb_reg_demux

Overview:
- APB3 slave that routes bus writes into one of four 8-bit register slots, selected by address. This is the write/decode direction of the 4-to-1 byte select path.
- Provides the CTRL byte and a TX byte, with a valid/ready handshake, toward the I2C engine.
- Captures RX bytes from the I2C engine for bus read-back.
- Sits between the APB bridge and the I2C core.

Parameters:
- ADDR_W, 4: PADDR width; bits [1:0] select the slot, bits [ADDR_W-1:2] must be zero.
- WAIT_STATES, 0: extra ACCESS cycles before PREADY (0..7).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  APB address
- PWDATA  in  8  write data
- PRDATA  out  8  read data, registered
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error; valid only while PREADY=1
- ctrl_out  out  8  CTRL register to the I2C core; bit 7 always 0
- tx_data  out  8  TX byte
- tx_valid  out  1  TX byte pending
- tx_ready  in  1  I2C core accepts the TX byte
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid, single-cycle strobe
- rx_full  out  1  RX register holds an unread byte
- rx_overrun  out  1  sticky flag: an RX byte was dropped

Behaviour:
- Reset (sync, rst=1 at a clk edge): FSM=IDLE, wait counter=0, and every output is 0 (PRDATA, PREADY, PSLVERR, ctrl_out, tx_data, tx_valid, rx_full, rx_overrun). The internal RX register is also 0.
  - Reset mid-transfer aborts the transfer with no register update.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSEL=1 and PENABLE=0.
  - SETUP -> ACCESS on the next edge if PSEL=1 and PENABLE=1; otherwise -> IDLE (protocol violation, no commit).
  - ACCESS: the counter increments each cycle. PREADY=1 in the cycle where counter==WAIT_STATES, giving total latency of 2+WAIT_STATES cycles from SETUP.
  - The write commits and PRDATA updates at the edge ending the PREADY cycle. Then: -> SETUP if PSEL=1 and PENABLE=0 (back-to-back), else -> IDLE.
  - If PSEL drops in ACCESS before PREADY: abort -> IDLE, no commit, PREADY stays 0.
- PREADY and PSLVERR are 0 outside the completion cycle.
- Slot decode, sel = PADDR[1:0]:
  - sel 0 (hold): write is ignored, no error. Read returns the previous PRDATA unchanged.
  - sel 1 (CTRL):
    - Write stores PWDATA[6:0] into ctrl_out[6:0].
    - PWDATA[7]=1 clears rx_overrun; bit 7 is not stored.
    - Read returns {rx_overrun, ctrl_out[6:0]}.
  - sel 2 (TXDATA):
    - Write with tx_valid=0: tx_data<=PWDATA, tx_valid<=1.
    - Write with tx_valid=1 and tx_ready=1 in the same cycle: the new data is accepted and tx_valid stays 1.
    - Write with tx_valid=1 and tx_ready=0: PSLVERR=1, data discarded.
    - Read returns tx_data.
  - sel 3 (RXDATA):
    - Read returns the RX register and clears rx_full.
    - Write: PSLVERR=1, no effect.
- Nonzero PADDR[ADDR_W-1:2]: PSLVERR=1, no write effect, PRDATA unchanged.
- TX handshake: tx_valid=1 and tx_ready=1 at an edge clears tx_valid. tx_data holds its value after the handshake.
- RX capture:
  - rx_valid=1 with rx_full=0: capture rx_data, set rx_full.
  - rx_valid=1 with rx_full=1: byte dropped, rx_overrun<=1 (sticky).
  - RXDATA read completing in the same cycle as rx_valid=1: PRDATA gets the old byte, the new byte is loaded, rx_full stays 1, no overrun.
  - CTRL write with bit 7 set, in the same cycle as an overrun event: overrun wins, rx_overrun=1.
- All outputs are registered except PREADY and PSLVERR, which are decoded from the registered state, counter, and latched address/command.

Test Plan:
- Reset, then write CTRL=0x85 with WAIT_STATES=0 -> PREADY in the 2nd cycle after SETUP; ctrl_out=0x05; read CTRL returns 0x05.
- rx_valid pulse with rx_data=0xA5, then a second pulse with 0x3C -> rx_full=1, rx_overrun=1. Read RXDATA returns 0xA5, rx_full=0. Write CTRL=0x80 -> rx_overrun=0.
- Write TXDATA=0x5A -> tx_data=0x5A, tx_valid=1. Write TXDATA=0x11 with tx_ready=0 -> PSLVERR=1, tx_data stays 0x5A. Pulse tx_ready -> tx_valid=0.
- WAIT_STATES=3, read TXDATA -> PREADY only on the 5th cycle from SETUP; PRDATA=0x5A. Then read sel 0 -> PRDATA stays 0x5A, PSLVERR=0.
- Write to sel 3, then access with PADDR=0x4 -> PSLVERR=1 for both, no state change. Drop PSEL mid-ACCESS -> no PREADY, no commit.
- rx_valid=1 (0x77) in the same cycle as an RXDATA read completion with the RX register holding 0x22 -> PRDATA=0x22, RX register=0x77, rx_full=1, rx_overrun=0. Assert rst mid-ACCESS -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/apb_reg_demux.sv
// APB3 slave steering byte writes into CTRL/TX slots
// and capturing RX bytes from the I2C engine.
module apb_reg_demux #(
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [7:0]        ctrl_out,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_full,
  output logic              rx_overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t            state;
  state_t            state_nx;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] a_q;
  logic              w_q;
  logic [7:0]        d_q;
  logic [6:0]        ctrl_q;
  logic [7:0]        rx_q;

  logic [1:0] sel;
  logic       hi_bad;
  logic       done;
  logic       err;
  logic       commit;
  logic       wr_ctrl;
  logic       wr_tx;
  logic       rd_any;
  logic       rd_rx;
  logic [7:0] rd_val;

  assign ctrl_out = {1'b0, ctrl_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: APB phase tracking with abort paths
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (PSEL && !PENABLE) state_nx = SETUP;
      end
      SETUP: begin
        if (PSEL && PENABLE) state_nx = ACCESS;
        else                 state_nx = IDLE;
      end
      ACCESS: begin
        if (done) begin
          if (PSEL && !PENABLE) state_nx = SETUP;
          else                  state_nx = IDLE;
        end else if (!PSEL) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Wait counter and command latch taken on SETUP entry
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
      a_q <= '0;
      w_q <= 1'b0;
      d_q <= 8'd0;
    end else begin
      if (state == ACCESS && state_nx == ACCESS)
        cnt <= cnt + 3'd1;
      else
        cnt <= 3'd0;
      if (state_nx == SETUP) begin
        a_q <= PADDR;
        w_q <= PWRITE;
        d_q <= PWDATA;
      end
    end
  end

  // Outputs: completion, error and slot decode
  always_comb begin
    sel     = a_q[1:0];
    hi_bad  = |a_q[ADDR_W-1:2];
    done    = (state == ACCESS) && (cnt == WS);
    err     = hi_bad
            || (w_q && sel == 2'd3)
            || (w_q && sel == 2'd2
                && tx_valid && !tx_ready);
    PREADY  = done;
    PSLVERR = done && err;
    commit  = done && !err;
    wr_ctrl = commit && w_q && sel == 2'd1;
    wr_tx   = commit && w_q && sel == 2'd2;
    rd_any  = commit && !w_q;
    rd_rx   = rd_any && sel == 2'd3;
    rd_val  = PRDATA;
    unique case (1'b1)
      sel == 2'd1: rd_val = {rx_overrun, ctrl_q};
      sel == 2'd2: rd_val = tx_data;
      sel == 2'd3: rd_val = rx_q;
      default:     rd_val = PRDATA;
    endcase
  end

  // Register file, TX handshake and RX capture
  always_ff @(posedge clk) begin
    if (rst) begin
      PRDATA     <= 8'd0;
      ctrl_q     <= 7'd0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      rx_q       <= 8'd0;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rd_any) PRDATA <= rd_val;
      if (wr_ctrl) ctrl_q <= d_q[6:0];
      if (wr_tx) begin
        tx_data  <= d_q;
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (rx_valid && (!rx_full || rd_rx)) begin
        rx_q    <= rx_data;
        rx_full <= 1'b1;
      end else if (rd_rx) begin
        rx_full <= 1'b0;
      end
      if (rx_valid && rx_full && !rd_rx)
        rx_overrun <= 1'b1;
      else if (wr_ctrl && d_q[7])
        rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_reg_demux.sv
// Bench for apb_reg_demux: two instances (0 and 3
// wait states), scoreboard on APB completions.
module tb_apb_reg_demux;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic       psel[2];
  logic       pen[2];
  logic       pwrite[2];
  logic [3:0] paddr[2];
  logic [7:0] pwdata[2];
  logic [7:0] prdata[2];
  logic       pready[2];
  logic       pslverr[2];
  logic [7:0] ctrl_out[2];
  logic [7:0] tx_data[2];
  logic       tx_valid[2];
  logic       tx_ready[2];
  logic [7:0] rx_data[2];
  logic       rx_valid[2];
  logic       rx_full[2];
  logic       rx_overrun[2];

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  apb_reg_demux #(.ADDR_W(4), .WAIT_STATES(WS0)) u0 (
    .clk(clk), .rst(rst[0]),
    .PSEL(psel[0]), .PENABLE(pen[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]),
    .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .ctrl_out(ctrl_out[0]), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_full(rx_full[0]), .rx_overrun(rx_overrun[0])
  );

  apb_reg_demux #(.ADDR_W(4), .WAIT_STATES(WS1)) u1 (
    .clk(clk), .rst(rst[1]),
    .PSEL(psel[1]), .PENABLE(pen[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]),
    .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .ctrl_out(ctrl_out[1]), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_full(rx_full[1]), .rx_overrun(rx_overrun[1])
  );

  // reference model state, one copy per instance
  logic [6:0] m_ctrl[2];
  logic       m_ovr[2];
  logic [7:0] m_txd[2];
  logic       m_txv[2];
  logic [7:0] m_rxr[2];
  logic       m_rxf[2];
  logic [7:0] m_prd[2];

  typedef struct packed {
    logic       err;
    logic [7:0] prd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit         pend[2];
  logic [7:0] pend_v[2];

  function automatic int wsof(int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic cmp(string name, int d,
                     logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h want=%h",
               name, d, act, exp);
    end
  endtask

  task automatic m_reset(int d);
    m_ctrl[d] = 7'd0;
    m_ovr[d]  = 1'b0;
    m_txd[d]  = 8'd0;
    m_txv[d]  = 1'b0;
    m_rxr[d]  = 8'd0;
    m_rxf[d]  = 1'b0;
    m_prd[d]  = 8'd0;
  endtask

  task automatic chk_status(int d);
    cmp("ctrl_out", d, ctrl_out[d], {1'b0, m_ctrl[d]});
    cmp("tx_data", d, tx_data[d], m_txd[d]);
    cmp("tx_valid", d, {7'd0, tx_valid[d]},
        {7'd0, m_txv[d]});
    cmp("rx_full", d, {7'd0, rx_full[d]},
        {7'd0, m_rxf[d]});
    cmp("rx_overrun", d, {7'd0, rx_overrun[d]},
        {7'd0, m_ovr[d]});
    cmp("prdata_hold", d, prdata[d], m_prd[d]);
  endtask

  // Full transfer; side inputs rxv/txr apply in the
  // completion cycle. Starts and ends #1 after a posedge.
  task automatic xfer(int d, bit wr, logic [3:0] a,
                      logic [7:0] wd, bit rxv,
                      logic [7:0] rxd, bit txr);
    exp_t       e;
    logic [1:0] sel;
    bit         err;
    bit         rd_rx;
    sel = a[1:0];
    err = (a[3:2] != 2'd0)
        || (wr && sel == 2'd3)
        || (wr && sel == 2'd2 && m_txv[d] && !txr);
    if (!err && !wr) begin
      if (sel == 2'd1) m_prd[d] = {m_ovr[d], m_ctrl[d]};
      if (sel == 2'd2) m_prd[d] = m_txd[d];
      if (sel == 2'd3) m_prd[d] = m_rxr[d];
    end
    e.err = err;
    e.prd = m_prd[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    // events at the completion edge, in causal order:
    // consumer handshake/read first, then new arrivals
    rd_rx = !err && !wr && sel == 2'd3;
    if (m_txv[d] && txr) m_txv[d] = 1'b0;
    if (!err && wr && sel == 2'd2) begin
      m_txd[d] = wd;
      m_txv[d] = 1'b1;
    end
    if (!err && wr && sel == 2'd1) begin
      m_ctrl[d] = wd[6:0];
      if (wd[7]) m_ovr[d] = 1'b0;
    end
    if (rd_rx) m_rxf[d] = 1'b0;
    if (rxv) begin
      if (m_rxf[d]) m_ovr[d] = 1'b1;
      else begin
        m_rxr[d] = rxd;
        m_rxf[d] = 1'b1;
      end
    end
    psel[d]   = 1'b1;
    pen[d]    = 1'b0;
    pwrite[d] = wr;
    paddr[d]  = a;
    pwdata[d] = wd;
    @(posedge clk); #1;
    cmp("ready_setup", d, {7'd0, pready[d]}, 8'd0);
    pen[d] = 1'b1;
    for (int k = 0; k <= wsof(d); k++) begin
      @(posedge clk); #1;
      if (k == wsof(d)) begin
        rx_valid[d] = rxv;
        rx_data[d]  = rxd;
        tx_ready[d] = txr;
      end
      cmp("ready_access", d, {7'd0, pready[d]},
          {7'd0, (k == wsof(d))});
    end
    @(posedge clk); #1;
    psel[d]     = 1'b0;
    pen[d]      = 1'b0;
    rx_valid[d] = 1'b0;
    tx_ready[d] = 1'b0;
    chk_status(d);
  endtask

  // mode 0: drop PSEL in ACCESS, 1: reset in ACCESS,
  // 2: SETUP without PENABLE
  task automatic abort_xfer(int d, int mode, bit wr,
                            logic [3:0] a, logic [7:0] wd);
    psel[d]   = 1'b1;
    pen[d]    = 1'b0;
    pwrite[d] = wr;
    paddr[d]  = a;
    pwdata[d] = wd;
    @(posedge clk); #1;
    if (mode == 2) begin
      psel[d] = 1'b0;
    end else begin
      pen[d] = 1'b1;
      @(posedge clk); #1;
      cmp("ready_pre_abort", d, {7'd0, pready[d]}, 8'd0);
      if (mode == 0) begin
        psel[d] = 1'b0;
        pen[d]  = 1'b0;
      end else begin
        rst[d] = 1'b1;
      end
    end
    @(posedge clk); #1;
    rst[d]  = 1'b0;
    psel[d] = 1'b0;
    pen[d]  = 1'b0;
    if (mode == 1) m_reset(d);
    chk_status(d);
    repeat (5) begin
      cmp("ready_after_abort", d, {7'd0, pready[d]}, 8'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic rx_pulse(int d, logic [7:0] v);
    rx_valid[d] = 1'b1;
    rx_data[d]  = v;
    @(posedge clk); #1;
    rx_valid[d] = 1'b0;
    if (m_rxf[d]) m_ovr[d] = 1'b1;
    else begin
      m_rxr[d] = v;
      m_rxf[d] = 1'b1;
    end
    chk_status(d);
  endtask

  task automatic tx_pulse(int d);
    tx_ready[d] = 1'b1;
    @(posedge clk); #1;
    tx_ready[d] = 1'b0;
    m_txv[d] = 1'b0;
    chk_status(d);
  endtask

  // Monitor: pop expectation on each PREADY
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (pend[d]) begin
          cmp("prdata", d, prdata[d], pend_v[d]);
          pend[d] = 1'b0;
        end
        if (pready[d] === 1'b1) begin
          if ((d == 0 && q0.size() == 0)
              || (d == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_pready dut%0d got=1 want=0",
                     d);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            cmp("pslverr", d, {7'd0, pslverr[d]},
                {7'd0, e.err});
            pend[d]   = 1'b1;
            pend_v[d] = e.prd;
          end
        end else begin
          cmp("pslverr_idle", d, {7'd0, pslverr[d]}, 8'd0);
        end
      end
    end
  end

  initial begin
    int         d;
    int         op;
    logic [3:0] a;
    for (int i = 0; i < 2; i++) begin
      rst[i]      = 1'b1;
      psel[i]     = 1'b0;
      pen[i]      = 1'b0;
      pwrite[i]   = 1'b0;
      paddr[i]    = 4'd0;
      pwdata[i]   = 8'd0;
      tx_ready[i] = 1'b0;
      rx_valid[i] = 1'b0;
      rx_data[i]  = 8'd0;
      pend[i]     = 1'b0;
      pend_v[i]   = 8'd0;
      m_reset(i);
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    mon_en = 1'b1;
    chk_status(0);
    chk_status(1);

    // zero wait states
    xfer(0, 1, 4'h1, 8'h85, 0, 8'h00, 0);
    cmp("ctrl_85", 0, ctrl_out[0], 8'h05);
    xfer(0, 0, 4'h1, 8'h00, 0, 8'h00, 0);
    cmp("rd_ctrl", 0, prdata[0], 8'h05);
    rx_pulse(0, 8'hA5);
    rx_pulse(0, 8'h3C);
    cmp("ovr_set", 0, {7'd0, rx_overrun[0]}, 8'd1);
    xfer(0, 0, 4'h3, 8'h00, 0, 8'h00, 0);
    cmp("rd_rx", 0, prdata[0], 8'hA5);
    cmp("rx_empty", 0, {7'd0, rx_full[0]}, 8'd0);
    xfer(0, 1, 4'h1, 8'h80, 0, 8'h00, 0);
    cmp("ovr_clr", 0, {7'd0, rx_overrun[0]}, 8'd0);
    xfer(0, 1, 4'h2, 8'h5A, 0, 8'h00, 0);
    xfer(0, 1, 4'h2, 8'h11, 0, 8'h00, 0);
    cmp("tx_kept", 0, tx_data[0], 8'h5A);
    tx_pulse(0);
    abort_xfer(0, 2, 1, 4'h1, 8'h7F);

    // three wait states
    xfer(1, 1, 4'h2, 8'h5A, 0, 8'h00, 0);
    tx_pulse(1);
    xfer(1, 0, 4'h2, 8'h00, 0, 8'h00, 0);
    cmp("rd_tx", 1, prdata[1], 8'h5A);
    xfer(1, 0, 4'h0, 8'h00, 0, 8'h00, 0);
    cmp("rd_hold", 1, prdata[1], 8'h5A);
    xfer(1, 1, 4'h3, 8'hEE, 0, 8'h00, 0);
    xfer(1, 0, 4'h4, 8'h00, 0, 8'h00, 0);
    xfer(1, 1, 4'h6, 8'h33, 0, 8'h00, 0);
    abort_xfer(1, 0, 1, 4'h1, 8'h44);
    rx_pulse(1, 8'h22);
    xfer(1, 0, 4'h3, 8'h00, 1, 8'h77, 0);
    cmp("rd_rx_old", 1, prdata[1], 8'h22);
    cmp("rx_refill", 1, {7'd0, rx_full[1]}, 8'd1);
    xfer(1, 0, 4'h3, 8'h00, 0, 8'h00, 0);
    cmp("rd_rx_new", 1, prdata[1], 8'h77);
    xfer(1, 1, 4'h1, 8'h2B, 0, 8'h00, 0);
    xfer(1, 1, 4'h2, 8'hC3, 0, 8'h00, 0);
    abort_xfer(1, 1, 1, 4'h2, 8'h99);

    // randomized traffic on both instances
    for (int i = 0; i < 160; i++) begin
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      if (op < 7) begin
        if ($urandom_range(0, 7) == 0)
          a = 4'($urandom_range(4, 15));
        else
          a = 4'($urandom_range(0, 3));
        xfer(d, 1'($urandom_range(0, 1)), a,
             8'($urandom), ($urandom_range(0, 3) == 0),
             8'($urandom), ($urandom_range(0, 3) == 0));
      end else if (op < 9) begin
        rx_pulse(d, 8'($urandom));
      end else begin
        tx_pulse(d);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    cmp("q0_drained", 0, 8'(q0.size()), 8'd0);
    cmp("q1_drained", 1, 8'(q1.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
